stage_wb: RTL
=============

Name: stage_wb

Overview:
Writeback stage, directly downstream of the memory stage. It registers the memory-stage result bundle and commits architectural state: register-file write, compare register, and the special-register (SR) file. It also owns the privilege state machine and trap sequencing. It raises exn/redirect to flush the front of the pipeline and supplies cmp_reg, scr and sr_rdata back upstream.

Parameters:
EVEC_RST  32'h0000_0100  reset value of EVEC (trap vector)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m_pc  in  32  memory-stage pc
m_nextpc  in  32  memory-stage pc+4
m_res  in  32  memory-stage result; for mtsr, [2:0] is the SR index
m_op3  in  32  store/mtsr data
m_rd  in  5  destination register
m_w_rd, m_w_cr, m_mtsr, m_scall, m_eret, m_udf, m_bubble  in  1 each  memory-stage flags (already bubble-gated)
m_cmp_res  in  2  compare result
sr_raddr  in  3  SR read index (mfsr in memory stage)
sr_rdata  out  32  SR read data
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
cmp_reg  out  2  architectural compare register
scr  out  2  saved compare register
exn  out  1  trap taken this cycle
redir  out  1  pc redirect (trap or eret)
redir_pc  out  32  redirect target
halted  out  1  double-fault halt

Behaviour:
- Stage register captures all m_* signals every posedge. Reset loads valid=0, so the stage holds a bubble.
- valid = !bubble && !kill. kill is a flop: set on any cycle where redir=1, clear otherwise. It squashes the younger instruction that arrives the cycle after a redirect.
- State machine, 2-bit, reset RUN:
  - RUN: taking a trap moves to TRAP.
  - TRAP: eret moves to RUN; any trap moves to HALT.
  - HALT: absorbing until rst; valid is forced to 0; halted=1.
- Trap conditions, on a valid instruction, priority udf > scall > (eret in RUN, treated as udf):
  - EPC <= scall ? nextpc : pc.
  - CAUSE <= 1 for scall, 2 for udf; a trap while in TRAP writes CAUSE <= 3.
  - scr <= cmp_reg.
  - exn=1, redir=1, redir_pc=EVEC.
  - rf and cr writes suppressed.
- eret in TRAP: redir=1, redir_pc=EPC, exn=0, state to RUN. The cr write with m_cmp_res proceeds (memory stage already substitutes scr).
- Commit on a valid, non-trapping instruction:
  - rf_we = w_rd && rd!=0; rf_waddr=rd; rf_wdata=res.
  - w_cr loads cmp_reg <= cmp_res at the edge.
  - mtsr writes SR[res[2:0]] <= op3.
- rf_we, exn, redir, redir_pc are combinational from the stage register. After reset all are 0 and redir_pc=EVEC.
- SR map:
  - 0 EPC, rw, reset 0
  - 1 CAUSE, rw, reset 0
  - 2 EVEC, rw, reset EVEC_RST, bits [1:0] forced to 0
  - 3 STATUS, read-only {30'b0, state}
  - 4 SCRATCH, rw, reset 0
  - 5-7 read 0; writes ignored
- sr_rdata is combinational from sr_raddr. If a valid mtsr in WB targets the same writable index, op3 is forwarded.
- cmp_reg and scr reset to 0. cmp_reg updates on edge only; no internal bypass.
- rst mid-trap: all state returns to reset values immediately; kill clears.

Decomposition:
- Package br32_pkg:
  - wb_state_t enum {RUN, TRAP, HALT}
  - SR index constants SR_EPC/SR_CAUSE/SR_EVEC/SR_STATUS/SR_SCRATCH
  - cause constants CAUSE_SCALL=1, CAUSE_UDF=2, CAUSE_DFAULT=3
- One sub-module, wb_srfile: SR storage, read mux, forwarding and the write port. The state machine and trap logic stay in stage_wb.

Test Plan:
- Reset, then idle bubbles -> rf_we=0, exn=0, cmp_reg=0, sr_rdata(2)=32'h100, halted=0.
- Valid w_rd rd=5 res=32'hDEAD_BEEF, then rd=0 -> rf_we=1 addr 5 data DEADBEEF; next cycle rf_we=0.
- Valid scall pc=0x200 nextpc=0x204 with cmp_reg=2 and a younger addi on the next cycle:
  - exn=1, redir_pc=0x100.
  - EPC=0x204, CAUSE=1, scr=2, STATUS=1.
  - The following instruction is squashed (rf_we=0).
- From TRAP, eret with cmp_res=2, w_cr=1 -> redir=1, redir_pc=0x204, exn=0, cmp_reg=2, STATUS=0.
- In TRAP, udf -> CAUSE=3, halted=1; later valid w_rd instructions produce rf_we=0 until rst.
- mtsr idx 4 op3=0x1234 with sr_raddr=4 the same cycle -> sr_rdata=0x1234 (forwarded). mtsr idx 3 -> STATUS unchanged.

Source files
------------

// File: rtl/br32_pkg.sv
// Shared types and constants for the br32 writeback stage.
//   wb_state_t   - privilege/trap state (RUN, TRAP, HALT)
//   SR_*         - special-register indices
//   CAUSE_*      - values written to CAUSE on a trap
//   mem_bundle_t - memory-stage result bundle held in the WB stage register
package br32_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        HALT = 2'd2
    } wb_state_t;

    localparam logic [2:0] SR_EPC     = 3'd0;
    localparam logic [2:0] SR_CAUSE   = 3'd1;
    localparam logic [2:0] SR_EVEC    = 3'd2;
    localparam logic [2:0] SR_STATUS  = 3'd3;
    localparam logic [2:0] SR_SCRATCH = 3'd4;

    localparam logic [31:0] CAUSE_SCALL  = 32'd1;
    localparam logic [31:0] CAUSE_UDF    = 32'd2;
    localparam logic [31:0] CAUSE_DFAULT = 32'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic [31:0] res;
        logic [31:0] op3;
        logic [4:0]  rd;
        logic        w_rd;
        logic        w_cr;
        logic        mtsr;
        logic        scall;
        logic        eret;
        logic        udf;
        logic        bubble;
        logic [1:0]  cmp_res;
    } mem_bundle_t;

    // Indices backed by storage; STATUS and 5-7 ignore writes.
    function automatic logic sr_writable(input logic [2:0] idx);
        return (idx == SR_EPC) || (idx == SR_CAUSE) ||
               (idx == SR_EVEC) || (idx == SR_SCRATCH);
    endfunction

endpackage

// File: rtl/stage_wb_if.sv
// Memory-stage -> writeback-stage bus plus the values WB feeds back.
//   master: memory-stage side (drives m_* and sr_raddr)
//   slave : writeback stage (drives commit, redirect and SR read data)
interface stage_wb_if;
    logic [31:0] m_pc;
    logic [31:0] m_nextpc;
    logic [31:0] m_res;
    logic [31:0] m_op3;
    logic [4:0]  m_rd;
    logic        m_w_rd;
    logic        m_w_cr;
    logic        m_mtsr;
    logic        m_scall;
    logic        m_eret;
    logic        m_udf;
    logic        m_bubble;
    logic [1:0]  m_cmp_res;
    logic [2:0]  sr_raddr;
    logic [31:0] sr_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  cmp_reg;
    logic [1:0]  scr;
    logic        exn;
    logic        redir;
    logic [31:0] redir_pc;
    logic        halted;

    modport master (
        output m_pc, m_nextpc, m_res, m_op3, m_rd, m_w_rd, m_w_cr, m_mtsr,
               m_scall, m_eret, m_udf, m_bubble, m_cmp_res, sr_raddr,
        input  sr_rdata, rf_we, rf_waddr, rf_wdata, cmp_reg, scr, exn,
               redir, redir_pc, halted
    );

    modport slave (
        input  m_pc, m_nextpc, m_res, m_op3, m_rd, m_w_rd, m_w_cr, m_mtsr,
               m_scall, m_eret, m_udf, m_bubble, m_cmp_res, sr_raddr,
        output sr_rdata, rf_we, rf_waddr, rf_wdata, cmp_reg, scr, exn,
               redir, redir_pc, halted
    );
endinterface

// File: rtl/wb_srfile.sv
// Special-register file: EPC, CAUSE, EVEC, SCRATCH storage, STATUS view,
// combinational read mux with forwarding of an in-flight mtsr.
//   we/waddr/wdata         - mtsr write port (committing instruction)
//   trap_we/epc/cause      - trap update of EPC and CAUSE
//   status                 - current state, read back as STATUS
//   raddr/rdata            - read port
//   epc/evec               - direct taps for redirect targets
module wb_srfile
    import br32_pkg::*;
#(
    parameter logic [31:0] EVEC_RST = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        trap_we,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_cause,
    input  logic [1:0]  status,
    input  logic [2:0]  raddr,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic [31:0] evec
);

    logic [31:0] cause;
    logic [31:0] scratch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc     <= '0;
            cause   <= '0;
            evec    <= {EVEC_RST[31:2], 2'b00};
            scratch <= '0;
        end else if (trap_we) begin
            epc   <= trap_epc;
            cause <= trap_cause;
        end else if (we) begin
            case (waddr)
                SR_EPC:     epc     <= wdata;
                SR_CAUSE:   cause   <= wdata;
                SR_EVEC:    evec    <= {wdata[31:2], 2'b00};
                SR_SCRATCH: scratch <= wdata;
                default:    ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            SR_EPC:     rdata = epc;
            SR_CAUSE:   rdata = cause;
            SR_EVEC:    rdata = evec;
            SR_STATUS:  rdata = {30'b0, status};
            SR_SCRATCH: rdata = scratch;
            default:    rdata = '0;
        endcase
        // Forward the value the pending mtsr will store, so a reader in the
        // memory stage sees it without a stall.
        if (we && sr_writable(raddr) && (waddr == raddr))
            rdata = (raddr == SR_EVEC) ? {wdata[31:2], 2'b00} : wdata;
    end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: registers the memory-stage bundle, commits rf/cr/SR
// writes, runs the RUN/TRAP/HALT machine and sequences traps and eret.
//   clk, rst - clock, async active-high reset
//   wb       - stage_wb_if.slave: m_* bundle in; rf write, cmp_reg, scr,
//              exn/redir/redir_pc, halted and SR read port out
module stage_wb
    import br32_pkg::*;
#(
    parameter logic [31:0] EVEC_RST = 32'h0000_0100
) (
    input  logic      clk,
    input  logic      rst,
    stage_wb_if.slave wb
);

    mem_bundle_t m_in, r;
    wb_state_t   state, state_nx;
    logic        kill;
    logic [1:0]  cmp_reg, scr;
    logic [31:0] epc, evec;

    logic        valid, trap, eret_ok, commit;
    logic [31:0] trap_cause, trap_epc;

    assign m_in = '{pc: wb.m_pc, nextpc: wb.m_nextpc, res: wb.m_res,
                    op3: wb.m_op3, rd: wb.m_rd, w_rd: wb.m_w_rd,
                    w_cr: wb.m_w_cr, mtsr: wb.m_mtsr, scall: wb.m_scall,
                    eret: wb.m_eret, udf: wb.m_udf, bubble: wb.m_bubble,
                    cmp_res: wb.m_cmp_res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r        <= '0;
            r.bubble <= 1'b1;
            kill     <= 1'b0;
            state    <= RUN;
            cmp_reg  <= '0;
            scr      <= '0;
        end else begin
            r     <= m_in;
            // The instruction behind a redirect was fetched down the wrong path.
            kill  <= wb.redir;
            state <= state_nx;
            if (trap)
                scr <= cmp_reg;
            else if (commit && r.w_cr)
                cmp_reg <= r.cmp_res;
        end
    end

    always_comb begin
        valid   = !r.bubble && !kill && (state != HALT);
        // eret outside TRAP is illegal and handled as udf.
        trap    = valid && (r.udf || r.scall || (r.eret && state == RUN));
        eret_ok = valid && r.eret && (state == TRAP) && !trap;
        commit  = valid && !trap;

        if (state == TRAP)                  trap_cause = CAUSE_DFAULT;
        else if (r.udf || !r.scall)         trap_cause = CAUSE_UDF;
        else                                trap_cause = CAUSE_SCALL;
        trap_epc = (r.scall && !r.udf) ? r.nextpc : r.pc;

        state_nx = state;
        case (state)
            RUN:     if (trap) state_nx = TRAP;
            TRAP:    if (trap) state_nx = HALT;
                     else if (eret_ok) state_nx = RUN;
            default: state_nx = HALT;
        endcase
    end

    wb_srfile #(.EVEC_RST(EVEC_RST)) u_srfile (
        .clk        (clk),
        .rst        (rst),
        .we         (commit && r.mtsr),
        .waddr      (r.res[2:0]),
        .wdata      (r.op3),
        .trap_we    (trap),
        .trap_epc   (trap_epc),
        .trap_cause (trap_cause),
        .status     (state),
        .raddr      (wb.sr_raddr),
        .rdata      (wb.sr_rdata),
        .epc        (epc),
        .evec       (evec)
    );

    assign wb.rf_we    = commit && r.w_rd && (r.rd != 5'd0);
    assign wb.rf_waddr = r.rd;
    assign wb.rf_wdata = r.res;
    assign wb.cmp_reg  = cmp_reg;
    assign wb.scr      = scr;
    assign wb.exn      = trap;
    assign wb.redir    = trap || eret_ok;
    assign wb.redir_pc = eret_ok ? epc : evec;
    assign wb.halted   = (state == HALT);

endmodule
